// File: rtl/char_buf_pkg.sv
// Shared types and constants for the character-memory sequencer.
// State codes are exported on state_dbg, so their encodings are fixed.
package char_buf_pkg;

    localparam int LANE_W         = 8;
    localparam int CHAR_W         = 6;
    localparam int CHARS_PER_WORD = 4;
    localparam int WORD_W         = LANE_W * CHARS_PER_WORD;

    typedef enum logic [2:0] {
        S_LOAD    = 3'd0,
        S_SETTLE  = 3'd1,
        S_RD_ADDR = 3'd2,
        S_RD_WAIT = 3'd3,
        S_EMIT    = 3'd4,
        S_DONE    = 3'd5
    } state_e;

endpackage

// File: rtl/char_lane_pack.sv
// Combinational lane merge (pack one character into a word) and lane
// extract (pull one character out of a word).
module char_lane_pack
    import char_buf_pkg::*;
(
    input  logic [WORD_W-1:0] wr_word,
    input  logic [1:0]        wr_lane,
    input  logic [CHAR_W-1:0] wr_char,
    output logic [WORD_W-1:0] merged_word,
    input  logic [WORD_W-1:0] rd_word,
    input  logic [1:0]        rd_lane,
    output logic [CHAR_W-1:0] rd_char
);

    // NOTE: every always_comb output gets a full default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        merged_word = wr_word;
        merged_word[LANE_W*wr_lane +: LANE_W] = {{(LANE_W-CHAR_W){1'b0}}, wr_char};
    end

    assign rd_char = rd_word[LANE_W*rd_lane +: CHAR_W];

endmodule

// File: rtl/char_buffer_ctrl.sv
// Single owner of the character dmem port: packs incoming characters into
// words during load, then streams them back out over valid/ready.
module char_buffer_ctrl
    import char_buf_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int CNT_W  = ADDR_W + 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              char_valid,
    input  logic [CHAR_W-1:0] char_data,
    output logic              char_ready,
    input  logic              end_text,
    input  logic              restart,
    output logic              out_valid,
    output logic [CHAR_W-1:0] out_char,
    input  logic              out_ready,
    output logic              done,
    output logic [CNT_W-1:0]  char_count,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_wren,
    input  logic [31:0]       mem_rdata,
    output logic [2:0]        state_dbg
);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [CNT_W-1:0]    rd_idx_q, rd_idx_d;
    logic                full_q, full_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic                mem_wren_q, mem_wren_d;

    logic                accept;
    logic [WORD_W-1:0]   merge_base;
    logic [WORD_W-1:0]   merged_word;
    logic [CHAR_W-1:0]   rd_char;

    // A fresh word starts at lane 0, so stale lanes never reach the memory.
    assign merge_base = (count_q[1:0] == 2'd0) ? '0 : word_q;
    assign accept     = char_valid & char_ready;

    char_lane_pack u_lane_pack (
        .wr_word     (merge_base),
        .wr_lane     (count_q[1:0]),
        .wr_char     (char_data),
        .merged_word (merged_word),
        .rd_word     (word_q),
        .rd_lane     (rd_idx_q[1:0]),
        .rd_char     (rd_char)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_LOAD;
            count_q     <= '0;
            rd_idx_q    <= '0;
            full_q      <= 1'b0;
            word_q      <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wren_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rd_idx_q    <= rd_idx_d;
            full_q      <= full_d;
            word_q      <= word_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wren_q  <= mem_wren_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        rd_idx_d    = rd_idx_q;
        full_d      = full_q;
        word_d      = word_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wren_d  = 1'b0;

        case (state_q)
            S_LOAD: begin
                if (accept) begin
                    word_d      = merged_word;
                    mem_wren_d  = 1'b1;
                    mem_addr_d  = count_q[CNT_W-1:2];
                    mem_wdata_d = merged_word;
                    count_d     = count_q + 1'b1;
                    if (count_q == '1) full_d = 1'b1;
                end
                if (end_text) begin
                    state_d = (count_d == '0 && !full_d) ? S_DONE : S_SETTLE;
                end
            end
            S_SETTLE: begin
                state_d    = S_RD_ADDR;
                mem_addr_d = rd_idx_q[CNT_W-1:2];
            end
            S_RD_ADDR: state_d = S_RD_WAIT;
            S_RD_WAIT: begin
                state_d = S_EMIT;
                word_d  = mem_rdata;
            end
            S_EMIT: begin
                if (out_ready) begin
                    rd_idx_d = rd_idx_q + 1'b1;
                    // A full buffer stores count 0, which the wrapped index meets last.
                    if (rd_idx_d == count_q) begin
                        state_d = S_DONE;
                    end else if (rd_idx_d[1:0] == 2'd0) begin
                        state_d    = S_RD_ADDR;
                        mem_addr_d = rd_idx_d[CNT_W-1:2];
                    end
                end
            end
            S_DONE:  state_d = S_DONE;
            default: state_d = S_LOAD;
        endcase

        if (restart) begin
            state_d    = S_LOAD;
            count_d    = '0;
            rd_idx_d   = '0;
            full_d     = 1'b0;
            word_d     = '0;
            mem_wren_d = 1'b0;
        end
    end

    always_comb begin
        char_ready = (state_q == S_LOAD) && !full_q;
        out_valid  = (state_q == S_EMIT);
        done       = (state_q == S_DONE);
        state_dbg  = state_q;
    end

    assign out_char   = rd_char;
    assign char_count = count_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_wren   = mem_wren_q;

endmodule

// File: tb/tb_char_buffer_ctrl.sv
// Self-checking bench for char_buffer_ctrl with a behavioural 4096x32 dmem.
module tb_char_buffer_ctrl;

    logic        clk;
    logic        resetn;
    logic        char_valid;
    logic [5:0]  char_data;
    logic        char_ready;
    logic        end_text;
    logic        restart;
    logic        out_valid;
    logic [5:0]  out_char;
    logic        out_ready;
    logic        done;
    logic [13:0] char_count;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_wren;
    logic [31:0] mem_rdata;
    logic [2:0]  state_dbg;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] dmem [4096];
    logic [5:0]  exp_chars [16];

    char_buffer_ctrl dut (
        .clk        (clk),
        .resetn     (resetn),
        .char_valid (char_valid),
        .char_data  (char_data),
        .char_ready (char_ready),
        .end_text   (end_text),
        .restart    (restart),
        .out_valid  (out_valid),
        .out_char   (out_char),
        .out_ready  (out_ready),
        .done       (done),
        .char_count (char_count),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wren   (mem_wren),
        .mem_rdata  (mem_rdata),
        .state_dbg  (state_dbg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single-port synchronous RAM: q reflects the address sampled at the last edge.
    always @(posedge clk) begin
        if (mem_wren) dmem[mem_addr] <= mem_wdata;
        mem_rdata <= dmem[mem_addr];
    end

    typedef struct {
        logic        cv;
        logic [5:0]  cd;
        logic        et;
        logic        ordy;
        logic [2:0]  st;
        logic        wren;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic        ov;
        logic [5:0]  oc;
        logic        dn;
        logic [13:0] cnt;
    } vec_t;

    vec_t tbl [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_restart();
        restart = 1'b1;
        step();
        restart = 1'b0;
    endtask

    task automatic load(input int n, input logic [5:0] base, input bit et_last);
        for (int i = 0; i < n; i++) begin
            char_valid   = 1'b1;
            char_data    = base + 6'(i);
            exp_chars[i] = base + 6'(i);
            end_text     = et_last && (i == n - 1);
            step();
            check("load_wren", mem_wren, 1);
        end
        char_valid = 1'b0;
        end_text   = 1'b0;
        if (!et_last) begin
            end_text = 1'b1;
            step();
            end_text = 1'b0;
        end
    endtask

    task automatic play(input int n, input int stall_at, input int stall_len, input bit check_gaps);
        int idx;
        int stalled;
        int gap;
        int cyc;
        bit gap_pending;
        idx = 0; stalled = 0; gap = 0; cyc = 0; gap_pending = 1'b0;
        out_ready = 1'b0;
        while (done !== 1'b1 && cyc < 200) begin
            if (out_valid === 1'b1) begin
                if (gap_pending) begin
                    if (check_gaps) check("valid_gap", gap, 2);
                    gap_pending = 1'b0;
                end
                check("out_char", out_char, (idx < 16) ? exp_chars[idx] : 6'h00);
                if (idx == stall_at && stalled < stall_len) begin
                    out_ready = 1'b0;
                    stalled++;
                end else begin
                    out_ready = 1'b1;
                    if (idx % 4 == 3) begin
                        gap_pending = 1'b1;
                        gap = 0;
                    end
                    idx++;
                end
            end else begin
                out_ready = 1'b0;
                if (gap_pending) gap++;
            end
            step();
            cyc++;
        end
        out_ready = 1'b0;
        check("emitted", idx, n);
        check("play_done", done, 1);
        check("valid_at_done", out_valid, 0);
        check("count_at_done", char_count, n);
    endtask

    initial begin
        int cyc;
        int hs;
        int bad;

        resetn = 1'b0; char_valid = 1'b0; char_data = '0; end_text = 1'b0;
        restart = 1'b0; out_ready = 1'b0;

        // Reset state, observed with no clock edge needed.
        #3;
        check("rst_state", state_dbg, 0);
        check("rst_ready", char_ready, 1);
        check("rst_wren", mem_wren, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_valid", out_valid, 0);
        check("rst_done", done, 0);
        check("rst_count", char_count, 0);
        #9 resetn = 1'b1;

        // Five characters 01..05, end_text, full playback, one row per edge.
        tbl[0]  = '{1'b1, 6'h01, 1'b0, 1'b0, 3'd0, 1'b1, 12'd0, 32'h00000001, 1'b0, 6'h00, 1'b0, 14'd1};
        tbl[1]  = '{1'b1, 6'h02, 1'b0, 1'b0, 3'd0, 1'b1, 12'd0, 32'h00000201, 1'b0, 6'h00, 1'b0, 14'd2};
        tbl[2]  = '{1'b1, 6'h03, 1'b0, 1'b0, 3'd0, 1'b1, 12'd0, 32'h00030201, 1'b0, 6'h00, 1'b0, 14'd3};
        tbl[3]  = '{1'b1, 6'h04, 1'b0, 1'b0, 3'd0, 1'b1, 12'd0, 32'h04030201, 1'b0, 6'h00, 1'b0, 14'd4};
        tbl[4]  = '{1'b1, 6'h05, 1'b0, 1'b0, 3'd0, 1'b1, 12'd1, 32'h00000005, 1'b0, 6'h00, 1'b0, 14'd5};
        tbl[5]  = '{1'b0, 6'h00, 1'b1, 1'b1, 3'd1, 1'b0, 12'd1, 32'h0,        1'b0, 6'h00, 1'b0, 14'd5};
        tbl[6]  = '{1'b0, 6'h00, 1'b0, 1'b1, 3'd2, 1'b0, 12'd0, 32'h0,        1'b0, 6'h00, 1'b0, 14'd5};
        tbl[7]  = '{1'b0, 6'h00, 1'b0, 1'b1, 3'd3, 1'b0, 12'd0, 32'h0,        1'b0, 6'h00, 1'b0, 14'd5};
        tbl[8]  = '{1'b0, 6'h00, 1'b0, 1'b1, 3'd4, 1'b0, 12'd0, 32'h0,        1'b1, 6'h01, 1'b0, 14'd5};
        tbl[9]  = '{1'b0, 6'h00, 1'b0, 1'b1, 3'd4, 1'b0, 12'd0, 32'h0,        1'b1, 6'h02, 1'b0, 14'd5};
        tbl[10] = '{1'b0, 6'h00, 1'b0, 1'b1, 3'd4, 1'b0, 12'd0, 32'h0,        1'b1, 6'h03, 1'b0, 14'd5};
        tbl[11] = '{1'b0, 6'h00, 1'b0, 1'b1, 3'd4, 1'b0, 12'd0, 32'h0,        1'b1, 6'h04, 1'b0, 14'd5};
        tbl[12] = '{1'b0, 6'h00, 1'b0, 1'b1, 3'd2, 1'b0, 12'd1, 32'h0,        1'b0, 6'h00, 1'b0, 14'd5};
        tbl[13] = '{1'b0, 6'h00, 1'b0, 1'b1, 3'd3, 1'b0, 12'd1, 32'h0,        1'b0, 6'h00, 1'b0, 14'd5};
        tbl[14] = '{1'b0, 6'h00, 1'b0, 1'b1, 3'd4, 1'b0, 12'd1, 32'h0,        1'b1, 6'h05, 1'b0, 14'd5};
        tbl[15] = '{1'b0, 6'h00, 1'b0, 1'b1, 3'd5, 1'b0, 12'd1, 32'h0,        1'b0, 6'h00, 1'b1, 14'd5};

        for (int i = 0; i < 16; i++) begin
            char_valid = tbl[i].cv;
            char_data  = tbl[i].cd;
            end_text   = tbl[i].et;
            out_ready  = tbl[i].ordy;
            step();
            check($sformatf("t1_state[%0d]", i), state_dbg, tbl[i].st);
            check($sformatf("t1_wren[%0d]", i), mem_wren, tbl[i].wren);
            check($sformatf("t1_addr[%0d]", i), mem_addr, tbl[i].addr);
            if (tbl[i].wren) check($sformatf("t1_wdata[%0d]", i), mem_wdata, tbl[i].wdata);
            check($sformatf("t1_valid[%0d]", i), out_valid, tbl[i].ov);
            if (tbl[i].ov) check($sformatf("t1_char[%0d]", i), out_char, tbl[i].oc);
            check($sformatf("t1_done[%0d]", i), done, tbl[i].dn);
            check($sformatf("t1_count[%0d]", i), char_count, tbl[i].cnt);
            check($sformatf("t1_ready[%0d]", i), char_ready, tbl[i].st == 3'd0);
        end
        char_valid = 1'b0; end_text = 1'b0; out_ready = 1'b0;

        // end_text with an empty buffer: done one edge later, no traffic.
        do_restart();
        check("t2_restart_state", state_dbg, 0);
        check("t2_restart_count", char_count, 0);
        end_text = 1'b1;
        step();
        end_text = 1'b0;
        check("t2_done", done, 1);
        check("t2_state", state_dbg, 5);
        for (int i = 0; i < 3; i++) begin
            check("t2_wren", mem_wren, 0);
            check("t2_valid", out_valid, 0);
            step();
        end

        // end_text together with the 4th character.
        do_restart();
        load(4, 6'h11, 1'b1);
        check("t3_state", state_dbg, 1);
        check("t3_count", char_count, 4);
        check("t3_wdata", mem_wdata, 32'h14131211);
        play(4, -1, 0, 1'b0);

        // Three-cycle stall on the second character.
        do_restart();
        load(5, 6'h21, 1'b0);
        play(5, 1, 3, 1'b0);

        // Nine characters, out_ready always high: two-cycle gaps after 4 and 8.
        do_restart();
        load(9, 6'h30, 1'b0);
        play(9, -1, 0, 1'b1);

        // restart in the middle of playback.
        do_restart();
        load(5, 6'h01, 1'b0);
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 20) begin
            step();
            cyc++;
        end
        check("t6_reached_emit", out_valid, 1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        restart = 1'b1;
        step();
        restart = 1'b0;
        check("t6_state", state_dbg, 0);
        check("t6_ready", char_ready, 1);
        check("t6_valid", out_valid, 0);
        check("t6_count", char_count, 0);
        check("t6_wren", mem_wren, 0);

        // Asynchronous reset during a write cycle.
        char_valid = 1'b1;
        char_data  = 6'h3f;
        step();
        char_valid = 1'b0;
        check("t7_wren_before", mem_wren, 1);
        #3 resetn = 1'b0;
        #1;
        check("t7_wren_async", mem_wren, 0);
        check("t7_state_async", state_dbg, 0);
        check("t7_count_async", char_count, 0);
        #2 resetn = 1'b1;

        // Fill all 16384 slots, then confirm full behaviour and full playback.
        char_valid = 1'b1;
        for (int i = 0; i < 16384; i++) begin
            char_data = 6'(i % 64);
            step();
        end
        check("t8_full_ready", char_ready, 0);
        check("t8_full_count", char_count, 0);
        char_data = 6'h2a;
        step();
        check("t8_no_write", mem_wren, 0);
        char_valid = 1'b0;
        end_text = 1'b1;
        step();
        end_text = 1'b0;
        check("t8_settle", state_dbg, 1);
        out_ready = 1'b1;
        hs = 0; bad = 0; cyc = 0;
        while (done !== 1'b1 && cyc < 40000) begin
            if (out_valid === 1'b1) begin
                if (out_char !== 6'(hs % 64)) bad++;
                hs++;
            end
            step();
            cyc++;
        end
        out_ready = 1'b0;
        check("t8_full_chars_bad", bad, 0);
        check("t8_full_emitted", hs, 16384);
        check("t8_full_done", done, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
